// File: rtl/apb_rtl_pkg.sv
// Shared types and response encodings for the APB completer memory.
package apb_rtl_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_slv_state_e;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_mem_bank.sv
// DEPTH x DATA_W byte-lane-writable storage with combinational read and async clear.
module apb_mem_bank #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int NUM_LANES = DATA_W / 8,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic [IDX_W-1:0]     idx,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DEPTH-1:0][NUM_LANES-1:0][7:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_mask[l]) mem[idx][l] <= wdata[l*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer in front of a word-organised, byte-strobed memory with
// programmable wait states and PSLVERR on misaligned or out-of-range access.
module apb_slave_mem
    import apb_rtl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int NUM_LANES = DATA_W / 8;
    localparam int OFF_W     = $clog2(NUM_LANES);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int WA_W      = ADDR_W - OFF_W;
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    apb_slv_state_e          state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    slverr_q, slverr_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    logic                    lat_wr, lat_err;
    logic [IDX_W-1:0]        lat_idx;
    logic [DATA_W-1:0]       lat_wdata;
    logic [NUM_LANES-1:0]    lat_strb;
    logic                    lat_en;

    logic [WA_W-1:0]         word_addr;
    logic [IDX_W-1:0]        setup_idx, mem_idx;
    logic                    setup, setup_err, cur_err;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_rdata, resp_rdata;

    // Decode straight off the bus in the setup cycle; later phases use the latched copy.
    assign setup     = PSEL & ~PENABLE;
    assign word_addr = PADDR[ADDR_W-1:OFF_W];
    assign setup_idx = IDX_W'(word_addr);
    assign setup_err = (|PADDR[OFF_W-1:0]) || (32'(word_addr) >= 32'(DEPTH));

    assign mem_idx    = (state_q == IDLE) ? setup_idx : lat_idx;
    assign cur_err    = (state_q == IDLE) ? setup_err : lat_err;
    assign resp_rdata = cur_err ? '0 : mem_rdata;

    apb_mem_bank #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk       (PCLK),
        .rst       (PRESET),
        .we        (mem_we),
        .lane_mask (lat_strb),
        .idx       (mem_idx),
        .wdata     (lat_wdata),
        .rdata     (mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        slverr_d = RESP_OKAY;
        rdata_d  = rdata_q;
        lat_en   = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    lat_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = setup_err ? RESP_ERR : RESP_OKAY;
                        if (!PWRITE) rdata_d = resp_rdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = RESP;
                    ready_d  = 1'b1;
                    slverr_d = lat_err ? RESP_ERR : RESP_OKAY;
                    if (!lat_wr) rdata_d = resp_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                ready_d  = 1'b1;
                slverr_d = slverr_q;
                if (!PSEL) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    slverr_d = RESP_OKAY;
                end else if (PENABLE) begin
                    // Completion edge: commit a legal write, drop back for the next setup.
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    slverr_d = RESP_OKAY;
                    mem_we   = lat_wr & ~lat_err;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            slverr_q  <= RESP_OKAY;
            rdata_q   <= '0;
            lat_wr    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_strb  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            if (lat_en) begin
                lat_wr    <= PWRITE;
                lat_err   <= setup_err;
                lat_idx   <= setup_idx;
                lat_wdata <= PWDATA;
                lat_strb  <= PSTRB;
            end
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;
    assign PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: two instances (0 and 3 wait states) checked
// every cycle against a transaction-level memory model.
module tb_apb_slave_mem;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        preset;
    logic [1:0]  psel, penable;
    logic        pwrite;
    logic [AW-1:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [31:0] prdata0, prdata1;

    always #5 clk = ~clk;

    apb_slave_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

    apb_slave_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1));

    // Reference memory contents per instance
    logic [31:0] mdl [2][DEPTH];

    // Expectations for the current cycle, posted by the driver
    bit          exp_rst, exp_vld, exp_ready, exp_err, exp_rd, exp_lit_en;
    int          exp_dut;
    logic [31:0] exp_rdata, exp_lit;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, exp_dut, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_rst) begin
            check("rst_pready",  {30'b0, pready1, pready0}, 32'h0);
            check("rst_pslverr", {30'b0, pslverr1, pslverr0}, 32'h0);
            check("rst_prdata0", prdata0, 32'h0);
            check("rst_prdata1", prdata1, 32'h0);
        end else if (exp_vld) begin
            check("pready", 32'(exp_dut != 0 ? pready1 : pready0), 32'(exp_ready));
            if (exp_ready) begin
                check("pslverr", 32'(exp_dut != 0 ? pslverr1 : pslverr0), 32'(exp_err));
                if (exp_rd) begin
                    check("prdata", exp_dut != 0 ? prdata1 : prdata0, exp_rdata);
                    if (exp_lit_en) check("prdata_lit", exp_dut != 0 ? prdata1 : prdata0, exp_lit);
                end
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel = 2'b00; penable = 2'b00;
            exp_vld = 1'b1; exp_ready = 1'b0;
        end
    endtask

    // One transfer; abort_at >= 0 drops PSEL in that access cycle instead of continuing.
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int abort_at, input bit lit_en, input logic [31:0] lit);
        int w;
        int idx;
        bit err;
        w   = (d != 0) ? 3 : 0;
        idx = int'(a[AW-1:2]);
        err = (a[1:0] != 2'b00) || (idx >= DEPTH);
        @(posedge clk); #1;
        psel = 2'b00; penable = 2'b00; psel[d] = 1'b1;
        pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        exp_vld = 1'b1; exp_dut = d; exp_ready = 1'b0; exp_rd = 1'b0; exp_lit_en = 1'b0;
        for (int k = 0; k <= w; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) begin
                psel = 2'b00; penable = 2'b00; exp_ready = 1'b0;
                return;
            end
            penable[d] = 1'b1;
            // Bus wiggles after setup must not reach the memory
            paddr = ~a; pwdata = ~wd; pstrb = ~st;
            exp_ready = (k == w);
            if (k == w) begin
                exp_err    = err;
                exp_rd     = !wr;
                exp_rdata  = err ? 32'h0 : mdl[d][idx];
                exp_lit_en = lit_en;
                exp_lit    = lit;
                if (wr && !err)
                    for (int b = 0; b < 4; b++)
                        if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
    endtask

    initial begin
        preset = 1'b1; psel = 2'b00; penable = 2'b00; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        exp_rst = 1'b1; exp_vld = 1'b0; exp_dut = 0; exp_ready = 1'b0; exp_err = 1'b0;
        exp_rd = 1'b0; exp_lit_en = 1'b0; exp_rdata = '0; exp_lit = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1; preset = 1'b0; exp_rst = 1'b0; exp_vld = 1'b1;
        idle(1);

        // zero-wait write then read
        xfer(0, 1, 10'h004, 32'hDEADBEEF, 4'hF, -1, 0, 0);
        xfer(0, 0, 10'h004, 32'h0, 4'hF, -1, 1, 32'hDEADBEEF);
        idle(1);

        // three wait states, read of cleared word
        xfer(1, 0, 10'h000, 32'h0, 4'h0, -1, 1, 32'h0);
        idle(1);

        // byte strobes, including an all-zero strobe
        xfer(0, 1, 10'h008, 32'h11223344, 4'hF, -1, 0, 0);
        xfer(0, 1, 10'h008, 32'hAABBCCDD, 4'b0101, -1, 0, 0);
        xfer(0, 0, 10'h008, 32'h0, 4'h0, -1, 1, 32'h11BB33DD);
        xfer(0, 1, 10'h008, 32'hFFFFFFFF, 4'h0, -1, 0, 0);
        xfer(0, 0, 10'h008, 32'h0, 4'h0, -1, 1, 32'h11BB33DD);
        idle(1);

        // error responses: out of range, misaligned; neighbours untouched
        xfer(0, 1, 10'h100, 32'h12345678, 4'hF, -1, 0, 0);
        xfer(0, 1, 10'h006, 32'h87654321, 4'hF, -1, 0, 0);
        xfer(0, 0, 10'h100, 32'h0, 4'h0, -1, 1, 32'h0);
        xfer(0, 0, 10'h004, 32'h0, 4'h0, -1, 1, 32'hDEADBEEF);
        xfer(0, 0, 10'h0FC, 32'h0, 4'h0, -1, 1, 32'h0);
        idle(1);

        // abort mid-wait leaves memory alone
        xfer(1, 1, 10'h010, 32'hCAFEF00D, 4'hF, 1, 0, 0);
        idle(2);
        xfer(1, 0, 10'h010, 32'h0, 4'h0, -1, 1, 32'h0);

        // back-to-back, no idle cycles, on both instances
        xfer(0, 1, 10'h020, 32'h01020304, 4'hF, -1, 0, 0);
        xfer(0, 0, 10'h020, 32'h0, 4'h0, -1, 1, 32'h01020304);
        xfer(0, 1, 10'h024, 32'hA5A5A5A5, 4'hF, -1, 0, 0);
        xfer(0, 0, 10'h024, 32'h0, 4'h0, -1, 1, 32'hA5A5A5A5);
        xfer(1, 1, 10'h030, 32'h0BADCAFE, 4'hF, -1, 0, 0);
        xfer(1, 0, 10'h030, 32'h0, 4'h0, -1, 1, 32'h0BADCAFE);
        xfer(1, 1, 10'h014, 32'h55AA55AA, 4'hF, -1, 0, 0);
        xfer(1, 0, 10'h014, 32'h0, 4'h0, -1, 1, 32'h55AA55AA);

        // reset asserted in the middle of a waited write
        @(posedge clk); #1;
        psel = 2'b10; penable = 2'b00; pwrite = 1'b1; paddr = 10'h00C;
        pwdata = 32'h13579BDF; pstrb = 4'hF;
        exp_dut = 1; exp_ready = 1'b0; exp_rd = 1'b0;
        @(posedge clk); #1;
        penable = 2'b10;
        @(posedge clk); #1;
        preset = 1'b1; exp_rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        preset = 1'b0; exp_rst = 1'b0; psel = 2'b00; penable = 2'b00; exp_ready = 1'b0;
        idle(1);
        xfer(1, 0, 10'h00C, 32'h0, 4'h0, -1, 1, 32'h0);
        xfer(1, 0, 10'h014, 32'h0, 4'h0, -1, 1, 32'h0);
        xfer(0, 0, 10'h004, 32'h0, 4'h0, -1, 1, 32'h0);
        idle(2);

        exp_vld = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
